// File: rtl/alu_pipe.sv
// alu_pipe: pipelined 16-op arithmetic/logic/shift unit with Z/N/C/V flags,
// valid/ready handshakes on both sides and an internal accumulator that can
// stand in for operand A so operations can be chained.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   synchronous reset, active low
//   in_valid   in   operand/op bundle valid
//   in_ready   out  bundle can be accepted this cycle (combinational on use_acc)
//   op         in   operation code (see op_e)
//   a, b       in   operands, WIDTH bits
//   use_acc    in   accumulator replaces a for this bundle
//   acc_clr    in   synchronous accumulator clear, wins over an update
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   y          out  result, WIDTH bits
//   flags      out  {Z,N,C,V} for y
//   bad_op     out  result came from reserved op 4'hF
//
// LATENCY=1 computes straight from the input bundle; LATENCY=2 adds an
// operand register stage in front of the compute/output stage.
module alu_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             bad_op
);

    typedef enum logic [3:0] {
        OP_PASS_A = 4'h0,
        OP_INC    = 4'h1,
        OP_ADD    = 4'h2,
        OP_ADDC   = 4'h3,
        OP_ADDNB  = 4'h4,
        OP_SUB    = 4'h5,
        OP_DEC    = 4'h6,
        OP_PASS_B = 4'h7,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOTA   = 4'hB,
        OP_SHL    = 4'hC,
        OP_SHR    = 4'hD,
        OP_ZERO   = 4'hE,
        OP_BAD    = 4'hF
    } op_e;

    // Output stage and accumulator state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             stall;
    logic             hazard;
    logic             accept;
    logic [WIDTH-1:0] op_a;

    // Bundle presented to the compute stage
    logic             ex_valid;
    op_e              ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;

    // Compute results
    logic [WIDTH-1:0] res_y;
    logic [3:0]       res_flags;
    logic             res_bad;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = rst_n & ~stall & ~hazard;
    assign accept   = in_valid & in_ready;
    assign op_a     = use_acc ? acc_q : a;

    if (LATENCY == 2) begin : g_lat2
        logic             s1_valid_q;
        op_e              s1_op_q;
        logic [WIDTH-1:0] s1_a_q;
        logic [WIDTH-1:0] s1_b_q;

        // A result still in stage 1 has not reached acc yet, so an
        // accumulator-sourced bundle must wait one cycle.
        assign hazard = use_acc & s1_valid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid_q <= 1'b0;
                s1_op_q    <= OP_PASS_A;
                s1_a_q     <= '0;
                s1_b_q     <= '0;
            end else if (!stall) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_op_q <= op_e'(op);
                    s1_a_q  <= op_a;
                    s1_b_q  <= b;
                end
            end
        end

        assign ex_valid = s1_valid_q;
        assign ex_op    = s1_op_q;
        assign ex_a     = s1_a_q;
        assign ex_b     = s1_b_q;
    end else begin : g_lat1
        assign hazard   = 1'b0;
        assign ex_valid = accept;
        assign ex_op    = op_e'(op);
        assign ex_a     = op_a;
        assign ex_b     = b;
    end

    // Arithmetic/logic core
    always_comb begin
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] addend;
        logic             cin;
        logic             c;
        logic             v;

        addend = '0;
        cin    = 1'b0;
        case (ex_op)
            OP_INC:   cin = 1'b1;
            OP_ADD:   addend = ex_b;
            OP_ADDC:  begin addend = ex_b;  cin = 1'b1; end
            OP_ADDNB: addend = ~ex_b;
            OP_SUB:   begin addend = ~ex_b; cin = 1'b1; end
            OP_DEC:   addend = '1;
            default:  ;
        endcase
        sum = {1'b0, ex_a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

        res_y   = '0;
        c       = 1'b0;
        v       = 1'b0;
        res_bad = 1'b0;
        case (ex_op)
            OP_PASS_A: res_y = ex_a;
            OP_INC, OP_ADD, OP_ADDC, OP_ADDNB, OP_SUB, OP_DEC: begin
                res_y = sum[WIDTH-1:0];
                c     = sum[WIDTH];
                v     = (ex_a[WIDTH-1] == addend[WIDTH-1]) &
                        (sum[WIDTH-1] != ex_a[WIDTH-1]);
            end
            OP_PASS_B: res_y = ex_b;
            OP_AND:    res_y = ex_a & ex_b;
            OP_OR:     res_y = ex_a | ex_b;
            OP_XOR:    res_y = ex_a ^ ex_b;
            OP_NOTA:   res_y = ~ex_a;
            OP_SHL: begin
                res_y = {ex_a[WIDTH-2:0], 1'b0};
                c     = ex_a[WIDTH-1];
            end
            OP_SHR: begin
                res_y = {1'b0, ex_a[WIDTH-1:1]};
                c     = ex_a[0];
            end
            OP_ZERO:   res_y = '0;
            OP_BAD:    res_bad = 1'b1;
        endcase
        res_flags = {(res_y == '0), res_y[WIDTH-1], c, v};
    end

    // Output register next state; acc follows every result written here
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        flags_d     = flags_q;
        bad_d       = bad_q;
        acc_d       = acc_q;
        if (!stall) begin
            out_valid_d = ex_valid;
            if (ex_valid) begin
                y_d     = res_y;
                flags_d = res_flags;
                bad_d   = res_bad;
                acc_d   = res_y;
            end
        end
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
            bad_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            bad_q       <= bad_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;
    assign bad_op    = bad_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: one LATENCY=1 and one LATENCY=2 instance share the
// input side; each has its own outputs and is checked against its own timing.
module tb_alu_pipe;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
    logic         acc_clr;
    logic         out_ready;

    logic         rdy1, ov1, bad1;
    logic [W-1:0] y1;
    logic [3:0]   fl1;
    logic         rdy2, ov2, bad2;
    logic [W-1:0] y2;
    logic [3:0]   fl2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .op(op), .a(a), .b(b), .use_acc(use_acc), .acc_clr(acc_clr),
        .out_valid(ov1), .out_ready(out_ready), .y(y1), .flags(fl1), .bad_op(bad1)
    );

    alu_pipe #(.WIDTH(W), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .op(op), .a(a), .b(b), .use_acc(use_acc), .acc_clr(acc_clr),
        .out_valid(ov2), .out_ready(out_ready), .y(y2), .flags(fl2), .bad_op(bad2)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [3:0]   fl;   // {Z,N,C,V}
        logic         bad;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 1'b0};
        vecs[1]  = '{4'h5, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011, 1'b0};
        vecs[2]  = '{4'h5, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0100, 1'b0};
        vecs[3]  = '{4'hC, 32'h8000_0001, 32'h0000_0000, 32'h0000_0002, 4'b0010, 1'b0};
        vecs[4]  = '{4'hD, 32'h8000_0001, 32'h0000_0000, 32'h4000_0000, 4'b0010, 1'b0};
        vecs[5]  = '{4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 4'b1000, 1'b1};
        vecs[6]  = '{4'hE, 32'h0000_1234, 32'h0000_0001, 32'h0000_0000, 4'b1000, 1'b0};
        vecs[7]  = '{4'h0, 32'h8000_0000, 32'h0000_0005, 32'h8000_0000, 4'b0100, 1'b0};
        vecs[8]  = '{4'h1, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 4'b0101, 1'b0};
        vecs[9]  = '{4'h3, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 4'b0000, 1'b0};
        vecs[10] = '{4'h4, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 4'b0010, 1'b0};
        vecs[11] = '{4'h6, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100, 1'b0};
        vecs[12] = '{4'h6, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 4'b0011, 1'b0};
        vecs[13] = '{4'h7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 4'b1000, 1'b0};
        vecs[14] = '{4'h8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100, 1'b0};
        vecs[15] = '{4'h9, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b0100, 1'b0};
        vecs[16] = '{4'hA, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 4'b1000, 1'b0};
        vecs[17] = '{4'hB, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000, 4'b1000, 1'b0};
        vecs[18] = '{4'hC, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0100, 1'b0};
        vecs[19] = '{4'hD, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001, 4'b0000, 1'b0};
        vecs[20] = '{4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; op = 4'h0; a = '0; b = '0;
        use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy1", rdy1, 0);
        chk("rst_rdy2", rdy2, 0);
        chk("rst_out1", {ov1, y1, fl1, bad1}, 0);
        chk("rst_out2", {ov2, y2, fl2, bad2}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Op table through both latencies
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), {ov1, y1, fl1, bad1},
                {1'b1, vecs[i].y, vecs[i].fl, vecs[i].bad});
            chk($sformatf("vec%0d_lat2_early", i), ov2, 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_lat2", i), {ov2, y2, fl2, bad2},
                {1'b1, vecs[i].y, vecs[i].fl, vecs[i].bad});
            chk($sformatf("vec%0d_lat1_drop", i), ov1, 0);
        end

        // Stall: result held for 3 cycles, then transfers once
        do_reset();
        op = 4'h2; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall_first", {ov1, y1, fl1}, {1'b1, 32'd7, 4'b0000});
        a = 32'd10; b = 32'd10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_rdy%0d", k), rdy1, 0);
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", k), {ov1, y1, fl1, bad1}, {1'b1, 32'd7, 4'b0000, 1'b0});
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("release_rdy", rdy1, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_next", {ov1, y1}, {1'b1, 32'd20});
        @(posedge clk); #1;
        chk("release_drain", ov1, 0);

        // Chain, LATENCY=1: acc preloaded with 100, cleared, then y=1..4
        do_reset();
        op = 4'h7; b = 32'd100; use_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0; op = 4'h1; use_acc = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("chain1_rdy%0d", k), rdy1, 1);
            @(posedge clk); #1;
            chk($sformatf("chain1_y%0d", k), {ov1, y1}, {1'b1, 32'(k)});
        end
        in_valid = 1'b0; use_acc = 1'b0;

        // Chain, LATENCY=2: acc_clr lands on the edge acc would take 100
        do_reset();
        op = 4'h7; b = 32'd100; use_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_override_y", {ov2, y2}, {1'b1, 32'd100});
        acc_clr = 1'b0; op = 4'h1; use_acc = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("chain2_rdy%0d", k), rdy2, 1);
            @(posedge clk); #1;
            chk($sformatf("chain2_hazard%0d", k), {rdy2, ov2}, 0);
            @(posedge clk); #1;
            chk($sformatf("chain2_y%0d", k), {ov2, y2}, {1'b1, 32'(k)});
        end
        in_valid = 1'b0; use_acc = 1'b0;

        // Reset with two bundles in flight (LATENCY=2)
        do_reset();
        op = 4'h2; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 32'd2; b = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flight_out", {ov2, y2}, {1'b1, 32'd2});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", rdy2, 0);
        @(posedge clk); #1;
        chk("midrst_out", {ov2, y2, fl2, bad2}, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        op = 4'h0; a = 32'h55; use_acc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; use_acc = 1'b0;
        chk("postrst_empty", ov2, 0);
        @(posedge clk); #1;
        chk("postrst_acc", {ov2, y2, fl2, bad2}, {1'b1, 32'd0, 4'b1000, 1'b0});
        @(posedge clk); #1;
        chk("postrst_drain", ov2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
